// File: rtl/cruise_control_param.sv
// ---------------------------------------------------------------------------
// cruise_control_param
//
// Parametrised cruise controller for the vehicle-speed model. Speed is
// integrated once per clock from the driver inputs. On top of the manual
// OFF behaviour the controller offers a governor (CRUISE) that steers speed
// toward a held setpoint, a STANDBY state that keeps the setpoint for a
// later resume, and a speed limiter (LIMIT) that caps speed at the setpoint
// while the driver keeps throttle control.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   throttle       driver accelerator pressed
//   set            engage / re-capture the setpoint at the current speed
//   limit_sel      sampled with an accepted set: 0 = cruise, 1 = limiter
//   accel          raise the setpoint while held (CRUISE/LIMIT only)
//   coast          lower the setpoint while held (CRUISE/LIMIT only)
//   cancel         disengage and clear the setpoint
//   resume         re-engage from STANDBY with the retained setpoint
//   brake          driver brake pressed
//   speed          current vehicle speed (registered)
//   cruisespeed    held setpoint (registered)
//   cruisecontrol  high while in CRUISE
//   limiter_active high while in LIMIT
//   state          OFF=0, CRUISE=1, STANDBY=2, LIMIT=3
// ---------------------------------------------------------------------------
module cruise_control_param #(
   parameter int WIDTH      = 8,
   parameter int MAX_SPEED  = 120,
   parameter int MIN_ENGAGE = 40,
   parameter int ACCEL_STEP = 1,
   parameter int BRAKE_STEP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             throttle,
   input  logic             set,
   input  logic             limit_sel,
   input  logic             accel,
   input  logic             coast,
   input  logic             cancel,
   input  logic             resume,
   input  logic             brake,
   output logic [WIDTH-1:0] speed,
   output logic [WIDTH-1:0] cruisespeed,
   output logic             cruisecontrol,
   output logic             limiter_active,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      CRUISE  = 2'd1,
      STANDBY = 2'd2,
      LIMIT   = 2'd3
   } stateT;

   // All arithmetic is done one bit wider than the outputs so that an
   // increment or decrement can never wrap before it is saturated.
   localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_SPEED);
   localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_ENGAGE);
   localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(ACCEL_STEP);
   localparam logic [WIDTH:0]   BRAKE_W = (WIDTH+1)'(BRAKE_STEP);
   localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX_SPEED);

   stateT            stateReg;
   stateT            nextState;
   logic [WIDTH-1:0] speedReg;
   logic [WIDTH-1:0] cruiseReg;
   logic [WIDTH:0]   speedWide;
   logic [WIDTH:0]   cruiseWide;
   logic [WIDTH:0]   speedUp;
   logic [WIDTH:0]   speedDown;
   logic [WIDTH:0]   nextSpeedWide;
   logic [WIDTH:0]   nextCruiseWide;
   logic [WIDTH-1:0] nextSpeed;
   logic [WIDTH-1:0] nextCruise;
   logic             engaged;

   assign speedWide  = {1'b0, speedReg};
   assign cruiseWide = {1'b0, cruiseReg};
   assign engaged    = (stateReg == CRUISE) || (stateReg == LIMIT);

   // Single-step speed moves, already saturated at the ceiling and at zero.
   // They are shared by every state so the saturation lives in one place.
   always_comb begin
      speedUp   = speedWide + ONE_W;
      speedDown = '0;
      if (speedUp > MAX_W) begin
         speedUp = MAX_W;
      end
      if (speedWide != '0) begin
         speedDown = speedWide - ONE_W;
      end
   end

   // Speed integration. The brake always wins; otherwise the behaviour
   // depends on the state held before this edge. In CRUISE the throttle is a
   // driver override, and without it speed creeps one step toward the
   // setpoint. In LIMIT an overshoot is pulled down even under throttle, and
   // throttle can only push speed up to the setpoint.
   always_comb begin
      nextSpeedWide = speedWide;
      if (brake) begin
         if (speedWide >= BRAKE_W) begin
            nextSpeedWide = speedWide - BRAKE_W;
         end else begin
            nextSpeedWide = '0;
         end
      end else begin
         case (stateReg)
            CRUISE: begin
               if (throttle) begin
                  nextSpeedWide = speedUp;
               end else if (speedWide < cruiseWide) begin
                  nextSpeedWide = speedUp;
               end else if (speedWide > cruiseWide) begin
                  nextSpeedWide = speedDown;
               end
            end
            LIMIT: begin
               if (speedWide > cruiseWide) begin
                  nextSpeedWide = speedDown;
               end else if (throttle && (speedWide < cruiseWide)) begin
                  nextSpeedWide = speedUp;
               end else if (!throttle) begin
                  nextSpeedWide = speedDown;
               end
            end
            default: begin
               nextSpeedWide = throttle ? speedUp : speedDown;
            end
         endcase
      end
      nextSpeed = (nextSpeedWide > MAX_W) ? MAX_N : nextSpeedWide[WIDTH-1:0];
   end

   // Mode and setpoint update, first matching rule wins. Set is refused
   // while braking or below the engage speed. Pressing accel and coast
   // together cancels out and leaves the setpoint alone. The coast floor is
   // the engage speed, so an engaged setpoint never drops below it.
   always_comb begin
      nextState      = stateReg;
      nextCruiseWide = cruiseWide;
      if (cancel && (stateReg != OFF)) begin
         nextState      = OFF;
         nextCruiseWide = '0;
      end else if (brake && engaged) begin
         nextState = STANDBY;
      end else if (set && !brake && (speedWide >= MIN_W)) begin
         nextState      = limit_sel ? LIMIT : CRUISE;
         nextCruiseWide = speedWide;
      end else if (resume && (stateReg == STANDBY) && (cruiseReg != '0)) begin
         nextState = CRUISE;
      end else if (engaged && accel && !coast) begin
         nextCruiseWide = cruiseWide + STEP_W;
         if (nextCruiseWide > MAX_W) begin
            nextCruiseWide = MAX_W;
         end
      end else if (engaged && coast && !accel) begin
         if (cruiseWide >= (MIN_W + STEP_W)) begin
            nextCruiseWide = cruiseWide - STEP_W;
         end else begin
            nextCruiseWide = MIN_W;
         end
      end
      nextCruise = (nextCruiseWide > MAX_W) ? MAX_N : nextCruiseWide[WIDTH-1:0];
   end

   // State register. The mode flags are registered from the next state so
   // they line up exactly with the registered state value and are never
   // both high.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg       <= OFF;
         speedReg       <= '0;
         cruiseReg      <= '0;
         cruisecontrol  <= 1'b0;
         limiter_active <= 1'b0;
      end else begin
         stateReg       <= nextState;
         speedReg       <= nextSpeed;
         cruiseReg      <= nextCruise;
         cruisecontrol  <= (nextState == CRUISE);
         limiter_active <= (nextState == LIMIT);
      end
   end

   assign speed       = speedReg;
   assign cruisespeed = cruiseReg;
   assign state       = stateReg;

endmodule

// File: tb/tb_cruise_control_param.sv
// ---------------------------------------------------------------------------
// tb_cruise_control_param
//
// Directed bench for cruise_control_param with default parameters
// (MAX_SPEED=120, MIN_ENGAGE=40, ACCEL_STEP=1, BRAKE_STEP=2). Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, so each
// expected value is the state after the edges just applied.
// ---------------------------------------------------------------------------
module tb_cruise_control_param;

   localparam logic [1:0] OFF_S     = 2'd0;
   localparam logic [1:0] CRUISE_S  = 2'd1;
   localparam logic [1:0] STANDBY_S = 2'd2;
   localparam logic [1:0] LIMIT_S   = 2'd3;

   logic       clk;
   logic       reset;
   logic       throttle;
   logic       set;
   logic       limit_sel;
   logic       accel;
   logic       coast;
   logic       cancel;
   logic       resume;
   logic       brake;
   logic [7:0] speed;
   logic [7:0] cruisespeed;
   logic       cruisecontrol;
   logic       limiter_active;
   logic [1:0] state;

   int checkCount;
   int passCount;
   int failCount;

   cruise_control_param dut (
      .clk            (clk),
      .reset          (reset),
      .throttle       (throttle),
      .set            (set),
      .limit_sel      (limit_sel),
      .accel          (accel),
      .coast          (coast),
      .cancel         (cancel),
      .resume         (resume),
      .brake          (brake),
      .speed          (speed),
      .cruisespeed    (cruisespeed),
      .cruisecontrol  (cruisecontrol),
      .limiter_active (limiter_active),
      .state          (state)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance the given number of rising edges with the current inputs held,
   // then settle 1 ns past the last edge before anything is sampled.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and on a miss reports tag, observed and
   // expected values.
   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Compare every output against the expected speed, setpoint and state;
   // the two mode flags follow from the expected state.
   task automatic checkOutput(input string tag, input int expSpeed, input int expCruise,
                              input logic [1:0] expState);
      checkValue({tag, ".speed"}, 32'(speed), 32'(expSpeed));
      checkValue({tag, ".cruisespeed"}, 32'(cruisespeed), 32'(expCruise));
      checkValue({tag, ".state"}, 32'(state), 32'(expState));
      checkValue({tag, ".cruisecontrol"}, 32'(cruisecontrol), 32'(expState == CRUISE_S));
      checkValue({tag, ".limiter_active"}, 32'(limiter_active), 32'(expState == LIMIT_S));
   endtask

   // Linear sequence of directed steps with hand-computed expectations.
   initial begin
      checkCount = 0;
      passCount  = 0;
      failCount  = 0;
      reset      = 1'b1;
      throttle   = 1'b1;
      set        = 1'b1;
      limit_sel  = 1'b0;
      accel      = 1'b0;
      coast      = 1'b0;
      cancel     = 1'b0;
      resume     = 1'b0;
      brake      = 1'b0;

      // Reset overrides throttle and set.
      applyStimulus(2);
      checkOutput("reset", 0, 0, OFF_S);

      // Manual acceleration, then a set below the engage speed is ignored.
      reset = 1'b0; set = 1'b0;
      applyStimulus(30);
      checkOutput("throttle30", 30, 0, OFF_S);
      throttle = 1'b0; set = 1'b1;
      applyStimulus(1);
      checkOutput("setLow", 29, 0, OFF_S);
      set = 1'b0;

      // Engage cruise at 50, override with throttle, then settle back.
      throttle = 1'b1;
      applyStimulus(21);
      checkOutput("reach50", 50, 0, OFF_S);
      throttle = 1'b0; set = 1'b1; limit_sel = 1'b0;
      applyStimulus(1);
      checkOutput("setCruise", 49, 50, CRUISE_S);
      set = 1'b0; throttle = 1'b1;
      applyStimulus(11);
      checkOutput("override60", 60, 50, CRUISE_S);
      throttle = 1'b0;
      applyStimulus(10);
      checkOutput("settle50", 50, 50, CRUISE_S);
      applyStimulus(3);
      checkOutput("hold50", 50, 50, CRUISE_S);

      // Brake to STANDBY, accel ignored there, coast down, resume.
      throttle = 1'b1;
      applyStimulus(10);
      throttle = 1'b0; brake = 1'b1;
      applyStimulus(1);
      checkOutput("brakeStandby", 58, 50, STANDBY_S);
      brake = 1'b0; accel = 1'b1;
      applyStimulus(2);
      checkOutput("accelStandby", 56, 50, STANDBY_S);
      accel = 1'b0;
      applyStimulus(26);
      checkOutput("coastDown30", 30, 50, STANDBY_S);
      resume = 1'b1;
      applyStimulus(1);
      checkOutput("resume", 29, 50, CRUISE_S);
      resume = 1'b0;
      applyStimulus(21);
      checkOutput("resumed50", 50, 50, CRUISE_S);

      // Setpoint adjust: speed trails the setpoint by one cycle.
      accel = 1'b1;
      applyStimulus(5);
      checkOutput("accel5", 54, 55, CRUISE_S);
      accel = 1'b0;
      applyStimulus(1);
      checkOutput("accelSettle", 55, 55, CRUISE_S);
      coast = 1'b1;
      applyStimulus(20);
      checkOutput("coastFloor", 40, 40, CRUISE_S);
      accel = 1'b1;
      applyStimulus(2);
      checkOutput("accelCoastBoth", 40, 40, CRUISE_S);
      accel = 1'b0; coast = 1'b0;

      // Cancel clears the setpoint; speed then decays and stops at zero.
      cancel = 1'b1;
      applyStimulus(1);
      checkOutput("cancel", 40, 0, OFF_S);
      cancel = 1'b0;
      applyStimulus(40);
      checkOutput("decay0", 0, 0, OFF_S);
      applyStimulus(2);
      checkOutput("floor0", 0, 0, OFF_S);

      // Limiter: throttle cannot exceed the setpoint, overshoot is pulled down.
      throttle = 1'b1;
      applyStimulus(60);
      throttle = 1'b0; set = 1'b1; limit_sel = 1'b1;
      applyStimulus(1);
      checkOutput("setLimit", 59, 60, LIMIT_S);
      set = 1'b0; limit_sel = 1'b0; throttle = 1'b1;
      applyStimulus(20);
      checkOutput("limitCap", 60, 60, LIMIT_S);
      coast = 1'b1;
      applyStimulus(5);
      checkOutput("limitCoast", 56, 55, LIMIT_S);
      coast = 1'b0;
      applyStimulus(1);
      checkOutput("limitSettle", 55, 55, LIMIT_S);
      throttle = 1'b0;
      applyStimulus(3);
      checkOutput("limitNoThrottle", 52, 55, LIMIT_S);
      brake = 1'b1;
      applyStimulus(1);
      checkOutput("limitBrake", 50, 55, STANDBY_S);
      brake = 1'b0; resume = 1'b1;
      applyStimulus(1);
      checkOutput("limitResume", 49, 55, CRUISE_S);
      resume = 1'b0; cancel = 1'b1;
      applyStimulus(1);
      checkOutput("cancel2", 50, 0, OFF_S);
      cancel = 1'b0;

      // Speed and setpoint saturate at the ceiling.
      throttle = 1'b1;
      applyStimulus(68);
      checkOutput("reach118", 118, 0, OFF_S);
      applyStimulus(5);
      checkOutput("satSpeed", 120, 0, OFF_S);
      set = 1'b1;
      applyStimulus(1);
      checkOutput("setAtMax", 120, 120, CRUISE_S);
      set = 1'b0; accel = 1'b1;
      applyStimulus(3);
      checkOutput("satCruise", 120, 120, CRUISE_S);
      accel = 1'b0;

      // Priority cases.
      throttle = 1'b0; set = 1'b1; brake = 1'b1;
      applyStimulus(1);
      checkOutput("setBrake", 118, 120, STANDBY_S);
      set = 1'b0; brake = 1'b0; cancel = 1'b1; resume = 1'b1;
      applyStimulus(1);
      checkOutput("cancelResume", 117, 0, OFF_S);
      cancel = 1'b0; resume = 1'b0; set = 1'b1;
      applyStimulus(1);
      checkOutput("reengage", 116, 117, CRUISE_S);
      set = 1'b0; reset = 1'b1; throttle = 1'b1;
      applyStimulus(1);
      checkOutput("midReset", 0, 0, OFF_S);

      // Brake saturation from speed 1 and engage exactly at the threshold.
      reset = 1'b0;
      applyStimulus(1);
      checkOutput("speed1", 1, 0, OFF_S);
      throttle = 1'b0; brake = 1'b1;
      applyStimulus(2);
      checkOutput("brakeSat0", 0, 0, OFF_S);
      brake = 1'b0; throttle = 1'b1;
      applyStimulus(40);
      throttle = 1'b0; set = 1'b1;
      applyStimulus(1);
      checkOutput("setAtMin", 39, 40, CRUISE_S);
      set = 1'b0; coast = 1'b1;
      applyStimulus(2);
      checkOutput("coastAtMin", 40, 40, CRUISE_S);
      coast = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
